four_bank_mem_ctrl: RTL and testbench

- Banked main-memory model directly downstream of the cache controller FSM.
- Consumes that FSM's wr/rd/addr/data_in stream and returns data_out, stall and busy.
- Interleaves 16-bit words across four banks selected by addr[2:1]. A cache-line fill or writeback touches all four banks on consecutive cycles.
- Each bank stays occupied for 4 cycles per access. Read data returns exactly 2 cycles after issue.

---
 rtl/four_bank_mem_ctrl_pkg.sv | 22 ++
 rtl/four_bank_mem_ctrl_bank.sv | 45 ++++
 rtl/four_bank_mem_ctrl.sv | 86 ++++++++
 tb/tb_four_bank_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/four_bank_mem_ctrl_pkg.sv
// Shared constants for the four-bank main memory and the cache FSM that sequences fills/writebacks.
// Used by four_bank_mem_ctrl and mem_bank (build macro FOUR_BANK_MEM_UNALIGNED_ERR_EN is consumed by the top).
package four_bank_mem_ctrl_pkg;

   localparam int DATA_W           = 16;
   localparam int ADDR_W           = 16;
   localparam int NUM_BANKS        = 4;
   localparam int BANK_LSB         = 1;
   localparam int BANK_MSB         = 2;
   localparam int BANK_BUSY_CYCLES = 4;
   localparam int RD_LATENCY       = 2;

   // Counter reload value: the issue cycle itself is not counted as busy.
   localparam logic [1:0] CNT_LOAD = 2'(BANK_BUSY_CYCLES - 1);

   typedef logic [BANK_MSB-BANK_LSB:0] bank_sel_t;

   function automatic bank_sel_t bank_of(input logic [ADDR_W-1:0] addr);
      return addr[BANK_MSB:BANK_LSB];
   endfunction

endpackage

// File: rtl/four_bank_mem_ctrl_bank.sv
// One memory bank: single-port word array, occupancy down-counter and read-capture register.
// Enables arrive already qualified (accepted, not in reset) from the top level.
module mem_bank
   import four_bank_mem_ctrl_pkg::*;
#(
   parameter int ROW_W = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROW_W-1:0]  row,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic              busy,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ROW_W];
   logic [1:0]        cnt;
   logic [DATA_W-1:0] data_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 2'd0;
      end else if (wr_en || rd_en) begin
         cnt <= CNT_LOAD;
      end else if (cnt != 2'd0) begin
         cnt <= cnt - 2'd1;
      end
   end

   // Stage 1 boundary: array word captured at the end of the issue cycle.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[row] <= wdata;
      end
      if (rd_en) begin
         data_p1 <= mem[row];
      end
   end

   assign busy  = (cnt != 2'd0);
   assign rdata = data_p1;

endmodule

// File: rtl/four_bank_mem_ctrl.sv
// Four-bank interleaved main memory behind the cache controller: bank decode, stall/err, shared read pipe.
// Build macro FOUR_BANK_MEM_UNALIGNED_ERR_EN: when defined, requests with addr[0]=1 are flagged as errors.
module four_bank_mem_ctrl
   import four_bank_mem_ctrl_pkg::*;
#(
   parameter int MEM_DEPTH_LOG2 = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr,
   input  logic              rd,
   output logic [DATA_W-1:0] data_out,
   output logic              stall,
   output logic [NUM_BANKS-1:0] busy,
   output logic              err
);

   localparam int ROW_W = MEM_DEPTH_LOG2 - 2;

   logic              req;
   logic              unaligned;
   logic              accept;
   logic              issue;
   bank_sel_t         bank;
   logic [ROW_W-1:0]  row;
   logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
   logic              addr_unused;

   logic              vld_p1;
   logic              vld_p2;
   bank_sel_t         bank_p1;
   logic [DATA_W-1:0] data_p2;

   // Address bits above the stored depth alias; bit 0 only matters for the unaligned check.
   assign addr_unused = ^addr;

`ifdef FOUR_BANK_MEM_UNALIGNED_ERR_EN
   assign unaligned = addr[0];
`else
   assign unaligned = 1'b0;
`endif

   assign bank   = bank_of(addr);
   assign row    = addr[MEM_DEPTH_LOG2:3];
   assign req    = rd | wr;
   assign err    = (rd & wr) | (req & unaligned);
   assign stall  = req & ~err & busy[bank];
   assign accept = req & ~err & ~stall;
   assign issue  = accept & ~rst;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      mem_bank #(
         .ROW_W (ROW_W)
      ) u_bank (
         .clk   (clk),
         .rst   (rst),
         .row   (row),
         .wdata (data_in),
         .wr_en (issue & wr & (bank == bank_sel_t'(b))),
         .rd_en (issue & rd & (bank == bank_sel_t'(b))),
         .busy  (busy[b]),
         .rdata (bank_rdata[b])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= issue & rd;
         vld_p2 <= vld_p1;
      end
   end

   // Stage 1 -> stage 2 boundary: pick the capturing bank's word into the shared output register.
   always_ff @(posedge clk) begin
      bank_p1 <= bank;
      data_p2 <= bank_rdata[bank_p1];
   end

   assign data_out = vld_p2 ? data_p2 : '0;

endmodule

// File: tb/tb_four_bank_mem_ctrl.sv
// Self-checking bench for four_bank_mem_ctrl against a cycle-count reference model.
// Honours FOUR_BANK_MEM_UNALIGNED_ERR_EN when the same macro is defined for the build.
module tb_four_bank_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        wr;
   logic        rd;
   logic [15:0] data_out;
   logic        stall;
   logic [3:0]  busy;
   logic        err;

   four_bank_mem_ctrl #(.MEM_DEPTH_LOG2(15)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .data_in  (data_in),
      .wr       (wr),
      .rd       (rd),
      .data_out (data_out),
      .stall    (stall),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: cycle index, per-bank first free cycle, word store, read results by due cycle.
   longint      cyc = 0;
   longint      free_at [4];
   logic [15:0] mem_m [int];
   logic [15:0] due_m [longint];

   logic        obs_stall, obs_err, exp_stall, exp_err;
   logic [3:0]  obs_busy, exp_busy;
   logic [15:0] obs_dout, exp_dout;

   task automatic step(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic rs = 1'b0);
      int   b;
      int   wi;
      logic reqm, accm;
      rd = r; wr = w; addr = a; data_in = d; rst = rs;
      #1;
      obs_stall = stall; obs_err = err; obs_busy = busy; obs_dout = data_out;
      b    = int'(a[2:1]);
      wi   = int'(a[15:1]);
      reqm = r | w;
`ifdef FOUR_BANK_MEM_UNALIGNED_ERR_EN
      exp_err = (r & w) | (reqm & a[0]);
`else
      exp_err = r & w;
`endif
      for (int i = 0; i < 4; i++) exp_busy[i] = (cyc < free_at[i]);
      exp_stall = reqm & ~exp_err & exp_busy[b];
      exp_dout  = due_m.exists(cyc) ? due_m[cyc] : 16'h0000;
      accm      = reqm & ~exp_err & ~exp_stall & ~rs;
      @(posedge clk);
      if (rs) begin
         for (int i = 0; i < 4; i++) free_at[i] = 0;
         due_m.delete();
      end else if (accm) begin
         free_at[b] = cyc + 4;
         if (w) mem_m[wi] = d;
         if (r) due_m[cyc + 2] = mem_m[wi];
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 16'h0000);
      total_cnt++; if (obs_busy !== 4'b0000) $display("FAIL reset_busy: got %b want 0000", obs_busy); else pass_cnt++;
      total_cnt++; if (obs_dout !== 16'h0000) $display("FAIL reset_dout: got %h want 0000", obs_dout); else pass_cnt++;
      total_cnt++; if (obs_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", obs_stall); else pass_cnt++;
      total_cnt++; if (obs_err !== 1'b0) $display("FAIL reset_err: got %b want 0", obs_err); else pass_cnt++;
   endtask

   task automatic test_prefill();
      for (int i = 0; i < 128; i++) begin
         step(1'b0, 1'b1, 16'(i * 2), 16'($urandom));
         total_cnt++;
         if (obs_stall !== exp_stall) $display("FAIL prefill_stall word %0d: got %b want %b", i, obs_stall, exp_stall);
         else pass_cnt++;
      end
      idle(4);
   endtask

   task automatic test_write_read();
      logic [15:0] d [8];
      logic        s [8];
      step(1'b0, 1'b1, 16'h0010, 16'hBEEF); s[0] = obs_stall; d[0] = obs_dout;
      for (int t = 1; t < 8; t++) begin
         if (t == 4) step(1'b1, 1'b0, 16'h0010, 16'h0000);
         else        step(1'b0, 1'b0, 16'h0000, 16'h0000);
         s[t] = obs_stall; d[t] = obs_dout;
      end
      total_cnt++; if (s[0] !== 1'b0) $display("FAIL wr_rd_stall_T0: got %b want 0", s[0]); else pass_cnt++;
      total_cnt++; if (s[4] !== 1'b0) $display("FAIL wr_rd_stall_T4: got %b want 0", s[4]); else pass_cnt++;
      total_cnt++; if (d[5] !== 16'h0000) $display("FAIL wr_rd_dout_T5: got %h want 0000", d[5]); else pass_cnt++;
      total_cnt++; if (d[6] !== 16'hBEEF) $display("FAIL wr_rd_dout_T6: got %h want beef", d[6]); else pass_cnt++;
      total_cnt++; if (d[7] !== 16'h0000) $display("FAIL wr_rd_dout_T7: got %h want 0000", d[7]); else pass_cnt++;
   endtask

   task automatic test_burst();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'(16'h0040 + 2 * i), 16'(i + 1));
      idle(4);
      for (int t = 0; t < 8; t++) begin
         if (t < 4) step(1'b1, 1'b0, 16'(16'h0040 + 2 * t), 16'h0000);
         else       step(1'b0, 1'b0, 16'h0000, 16'h0000);
         total_cnt++;
         if (obs_busy !== exp_busy) $display("FAIL burst_busy T%0d: got %b want %b", t, obs_busy, exp_busy); else pass_cnt++;
         total_cnt++;
         if (t < 4 && obs_stall !== 1'b0) $display("FAIL burst_stall T%0d: got %b want 0", t, obs_stall); else pass_cnt++;
         if (t >= 2 && t <= 5) begin
            total_cnt++;
            if (obs_dout !== 16'(t - 1)) $display("FAIL burst_dout T%0d: got %h want %h", t, obs_dout, 16'(t - 1));
            else pass_cnt++;
         end
         if (t == 1) begin
            total_cnt++; if (obs_busy !== 4'b0001) $display("FAIL burst_busy_T1: got %b want 0001", obs_busy); else pass_cnt++;
         end
         if (t == 7) begin
            total_cnt++; if (obs_busy !== 4'b0000) $display("FAIL burst_busy_T7: got %b want 0000", obs_busy); else pass_cnt++;
         end
      end
   endtask

   task automatic test_conflict();
      int nstall = 0;
      int tries  = 0;
      idle(4);
      step(1'b1, 1'b0, 16'h0000, 16'h0000);
      do begin
         step(1'b1, 1'b0, 16'h0008, 16'h0000);
         total_cnt++;
         if (obs_stall !== exp_stall) $display("FAIL conflict_stall try %0d: got %b want %b", tries, obs_stall, exp_stall);
         else pass_cnt++;
         if (obs_stall === 1'b1) nstall++;
         tries++;
      end while (obs_stall === 1'b1 && tries < 10);
      total_cnt++; if (nstall != 3) $display("FAIL conflict_stall_cycles: got %0d want 3", nstall); else pass_cnt++;
      idle(1);
      step(1'b0, 1'b0, 16'h0000, 16'h0000);
      total_cnt++; if (obs_dout !== mem_m[4]) $display("FAIL conflict_dout_T6: got %h want %h", obs_dout, mem_m[4]); else pass_cnt++;
   endtask

   task automatic test_error();
      logic [15:0] old;
      idle(4);
      old = mem_m[1];
      step(1'b1, 1'b0, 16'h0002, 16'h0000);
      step(1'b1, 1'b1, 16'h0002, 16'h1234);
      total_cnt++; if (obs_err !== 1'b1) $display("FAIL rdwr_err: got %b want 1", obs_err); else pass_cnt++;
      total_cnt++; if (obs_stall !== 1'b0) $display("FAIL rdwr_stall: got %b want 0", obs_stall); else pass_cnt++;
      for (int t = 2; t < 5; t++) begin
         step(1'b0, 1'b0, 16'h0000, 16'h0000);
         total_cnt++;
         if (obs_dout !== exp_dout) $display("FAIL rdwr_dout T%0d: got %h want %h", t, obs_dout, exp_dout); else pass_cnt++;
         total_cnt++;
         if (obs_busy !== exp_busy) $display("FAIL rdwr_busy T%0d: got %b want %b", t, obs_busy, exp_busy); else pass_cnt++;
      end
      total_cnt++; if (obs_busy !== 4'b0000) $display("FAIL rdwr_busy_T4: got %b want 0000", obs_busy); else pass_cnt++;
      step(1'b1, 1'b0, 16'h0002, 16'h0000);
      idle(2);
      total_cnt++; if (obs_dout !== old) $display("FAIL rdwr_mem: got %h want %h", obs_dout, old); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] old;
      idle(4);
      old = mem_m[16'h0011];
      step(1'b1, 1'b0, 16'h0020, 16'h0000);
      step(1'b0, 1'b1, 16'h0022, 16'hAAAA, 1'b1);
      step(1'b0, 1'b0, 16'h0000, 16'h0000);
      total_cnt++; if (obs_dout !== 16'h0000) $display("FAIL rstmid_dout_T2: got %h want 0000", obs_dout); else pass_cnt++;
      total_cnt++; if (obs_busy !== 4'b0000) $display("FAIL rstmid_busy_T2: got %b want 0000", obs_busy); else pass_cnt++;
      step(1'b1, 1'b0, 16'h0022, 16'h0000);
      total_cnt++; if (obs_dout !== 16'h0000) $display("FAIL rstmid_dout_T3: got %h want 0000", obs_dout); else pass_cnt++;
      idle(2);
      total_cnt++; if (obs_dout !== old) $display("FAIL rstmid_ignored_wr: got %h want %h", obs_dout, old); else pass_cnt++;
   endtask

   task automatic test_unaligned();
      logic [15:0] want;
      idle(4);
`ifdef FOUR_BANK_MEM_UNALIGNED_ERR_EN
      want = mem_m[1];
`else
      want = 16'h5A5A;
`endif
      step(1'b0, 1'b1, 16'h0003, 16'h5A5A);
      total_cnt++; if (obs_err !== exp_err) $display("FAIL unaligned_err: got %b want %b", obs_err, exp_err); else pass_cnt++;
      idle(4);
      step(1'b1, 1'b0, 16'h0002, 16'h0000);
      idle(2);
      total_cnt++; if (obs_dout !== want) $display("FAIL unaligned_data: got %h want %h", obs_dout, want); else pass_cnt++;
   endtask

   task automatic test_random();
      logic r, w, rs;
      for (int t = 0; t < 400; t++) begin
         r  = 1'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 3) == 0);
         rs = 1'($urandom_range(0, 63) == 0);
         step(r, w, 16'($urandom_range(0, 255)), 16'($urandom), rs);
         total_cnt++; if (obs_stall !== exp_stall) $display("FAIL rand_stall cyc %0d: got %b want %b", cyc, obs_stall, exp_stall); else pass_cnt++;
         total_cnt++; if (obs_err !== exp_err) $display("FAIL rand_err cyc %0d: got %b want %b", cyc, obs_err, exp_err); else pass_cnt++;
         total_cnt++; if (obs_busy !== exp_busy) $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, obs_busy, exp_busy); else pass_cnt++;
         total_cnt++; if (obs_dout !== exp_dout) $display("FAIL rand_dout cyc %0d: got %h want %h", cyc, obs_dout, exp_dout); else pass_cnt++;
      end
   endtask

   initial begin
      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
      for (int i = 0; i < 4; i++) free_at[i] = 0;
      @(negedge clk);
      test_reset();
      test_prefill();
      test_write_read();
      test_burst();
      test_conflict();
      test_error();
      test_reset_mid();
      test_unaligned();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
